pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central sequencing unit for the five-stage core pipeline: generates per-register advance/flush controls for IF/ID, ID/EX, EX/MEM and MEM/WB plus the PC enable from cache hit signals, data-access status, load-use hazards, control redirects and halt. It holds pending conditions, such as a redirect that arrives during an instruction miss, until they can legally be applied. It also keeps saturating stall and flush counters for per-core performance readout. One instance per core sits beside the datapath, between the caches' hit lines and the pipeline registers.

## Interface
- CNTW, 32, width of the performance counters
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction cache hit this cycle
- dhit  in  1  data cache hit this cycle
- em_memreq  in  1  EX/MEM holds a data access (dmemREN | dmemWEN)
- de_memread  in  1  ID/EX holds a load
- de_wsel  in  5  ID/EX destination register
- fd_rs, fd_rt  in  5 each  IF/ID source registers
- em_redirect  in  1  branch/jump in EX/MEM changes PC (single-cycle pulse)
- mw_halt  in  1  halt has reached MEM/WB
- pc_en  out  1  PC may update
- fd_en, de_en, em_en, mw_en  out  1 each  register captures its inputs
- fd_flush, de_flush, em_flush  out  1 each  register loads bubble (zeros)
- halted  out  1  core stopped, sticky
- stall_cycles  out  CNTW  cycles with pc_en=0 while not HALTED
- flush_count  out  CNTW  redirect flushes applied

## Operation
- States: RUN, DWAIT, REDIRECT, HALTED.
- Signals: dwait = em_memreq & ~dhit. lu = de_memread & (de_wsel≠0) & (de_wsel==fd_rs | de_wsel==fd_rt).
- Priority within a cycle: HALTED > mw_halt > redirect > dwait > load-use > ihit miss.
- RUN:
  - If mw_halt: all enables 0, go to HALTED.
  - Else if em_redirect & ihit: fd/de/em_flush=1, pc_en=1, mw_en=1, flush_count+1, stay in RUN.
  - Else if em_redirect & ~ihit: latch pending redirect, go to REDIRECT. All enables 0, except mw_en = ~dwait.
  - Else if dwait: all enables 0, go to DWAIT.
  - Else if ihit & lu: pc_en=0, fd_en=0, de_flush=1, em_en=1, mw_en=1.
  - Else if ihit: all enables 1.
  - Else (~ihit): all enables 0, except em_en = mw_en = 1 when em_memreq & dhit, so the access retires.
- DWAIT:
  - Enables stay 0 until dhit.
  - On dhit: mw_en=1, em_en=1. pc_en, fd_en and de_en = ihit.
  - Return to RUN on dhit. mw_halt or em_redirect arriving here is handled in RUN on the following cycle.
- REDIRECT:
  - Hold until ihit, then apply fd/de/em_flush=1 and pc_en=1, increment flush_count, return to RUN.
  - mw_halt takes priority: drop the pending redirect and go to HALTED.
- HALTED: all enables and flushes 0, halted=1. Leaves only via reset.
- Flush and enable for the same register are never both 1. Flush takes precedence and implies capture.
- Counters saturate at 2^CNTW−1. No wrap.

## Timing
- State and counters are registered. All control outputs are combinational (Mealy) from state and current inputs. No added latency: a redirect with ihit=1 flushes on the same edge.
- Redirect during an ihit miss: flush is applied on the first subsequent ihit cycle, at least 1 cycle later.
- Load-use: exactly one bubble per hazard when ihit=1. Extended by ihit misses.
- halted rises the cycle after mw_halt is sampled.
- Reset: state=RUN, pending=0, halted=0, counters=0. While nRST=0, all enables and flushes are 0.
- Reset asserted mid-DWAIT or mid-REDIRECT: the pending redirect and state are discarded immediately (asynchronous).

## Structure
- Shared package (cpu_types_pkg): pipe_state_t enum {RUN, DWAIT, REDIRECT, HALTED} and regbits_t for register indices.
- Sub-module: perf_counter, a saturating counter with increment and width parameter, instantiated twice.
- State register, pending latch and output decode live in pipeline_ctrl.

## Test plan
- Load-use: de_memread=1, de_wsel=8, fd_rs=8, ihit=1 -> one cycle with pc_en=0, fd_en=0, de_flush=1, em_en=1. Next cycle all enables 1. stall_cycles=1.
- Data miss: em_memreq=1, dhit=0 for 3 cycles, then dhit=1 with ihit=1 -> enables 0 for 3 cycles, then all 1 in the same cycle. stall_cycles=3.
- Redirect during miss: em_redirect pulse with ihit=0, ihit stays low 2 cycles -> state REDIRECT. On ihit=1: fd/de/em_flush=1, pc_en=1, flush_count=1.
- Redirect plus dwait in the same cycle -> redirect wins: flushes on ihit, em_flush=1, em_en not separately asserted.
- Halt: mw_halt=1 -> next cycle halted=1, all enables 0 indefinitely. Counters frozen.
- Saturation: CNTW=4, hold ihit=0 for 20 cycles -> stall_cycles stays at 15. Assert nRST mid-stall -> all outputs 0, counters 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared pipeline control types
package cpu_types_pkg;
    typedef enum logic [1:0] {RUN, DWAIT, REDIRECT, HALTED} pipe_state_t;
    typedef logic [4:0] regbits_t;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/hit inputs and per-register controls between datapath and pipeline_ctrl
interface pipeline_ctrl_if #(
    parameter int CNTW = 32
);
    import cpu_types_pkg::*;
    logic ihit, dhit, em_memreq, de_memread, em_redirect, mw_halt;
    regbits_t de_wsel, fd_rs, fd_rt;
    logic pc_en, fd_en, de_en, em_en, mw_en;
    logic fd_flush, de_flush, em_flush, halted;
    logic [CNTW-1:0] stall_cycles, flush_count;
    modport master (
        output ihit, dhit, em_memreq, de_memread, em_redirect, mw_halt, de_wsel, fd_rs, fd_rt,
        input pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, halted,
        input stall_cycles, flush_count
    );
    modport slave (
        input ihit, dhit, em_memreq, de_memread, em_redirect, mw_halt, de_wsel, fd_rs, fd_rt,
        output pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, halted,
        output stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl_perf_counter.sv
// perf_counter: saturating event counter
module perf_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline advance/flush sequencing with stall and flush performance counters
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNTW = 32
) (
    input logic CLK,
    input logic nRST,
    pipeline_ctrl_if.slave pif
);
    pipe_state_t state, next_state;
    logic dwait, lu, apply;
    assign dwait = pif.em_memreq & ~pif.dhit;
    assign lu = pif.de_memread & (pif.de_wsel != '0) &
                (pif.de_wsel == pif.fd_rs | pif.de_wsel == pif.fd_rt);
    assign pif.halted = state == HALTED;
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) state <= RUN;
        else state <= next_state;
    // REDIRECT doubles as the pending-redirect latch; reset drops it asynchronously
    always_comb begin
        next_state = state;
        apply = 1'b0;
        {pif.pc_en, pif.fd_en, pif.de_en, pif.em_en, pif.mw_en} = '0;
        {pif.fd_flush, pif.de_flush, pif.em_flush} = '0;
        if (nRST) begin
            case (state)
                RUN:
                    if (pif.mw_halt) next_state = HALTED;
                    else if (pif.em_redirect & pif.ihit) begin
                        apply = 1'b1;
                        pif.pc_en = 1'b1;
                        pif.mw_en = 1'b1;
                        {pif.fd_flush, pif.de_flush, pif.em_flush} = '1;
                    end else if (pif.em_redirect) begin
                        next_state = REDIRECT;
                        pif.mw_en = ~dwait;
                    end else if (dwait) next_state = DWAIT;
                    else if (pif.ihit & lu) begin
                        pif.de_flush = 1'b1;
                        {pif.em_en, pif.mw_en} = '1;
                    end else if (pif.ihit) {pif.pc_en, pif.fd_en, pif.de_en, pif.em_en, pif.mw_en} = '1;
                    else {pif.em_en, pif.mw_en} = {2{pif.em_memreq & pif.dhit}};
                DWAIT:
                    if (pif.dhit) begin
                        next_state = RUN;
                        {pif.em_en, pif.mw_en} = '1;
                        {pif.pc_en, pif.fd_en, pif.de_en} = {3{pif.ihit}};
                    end
                REDIRECT:
                    if (pif.mw_halt) next_state = HALTED;
                    else if (pif.ihit) begin
                        next_state = RUN;
                        apply = 1'b1;
                        pif.pc_en = 1'b1;
                        {pif.fd_flush, pif.de_flush, pif.em_flush} = '1;
                    end
                default: ;
            endcase
        end
    end
    perf_counter #(.W(CNTW)) u_stall (
        .CLK(CLK), .nRST(nRST), .inc(~pif.pc_en & (state != HALTED)), .cnt(pif.stall_cycles)
    );
    perf_counter #(.W(CNTW)) u_flush (
        .CLK(CLK), .nRST(nRST), .inc(apply), .cnt(pif.flush_count)
    );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vector bench for pipeline_ctrl with 4-bit counters
module tb_pipeline_ctrl;
    localparam int CNTW = 4;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int checks = 0;
    int failures = 0;
    pipeline_ctrl_if #(.CNTW(CNTW)) pif ();
    pipeline_ctrl #(.CNTW(CNTW)) dut (.CLK(CLK), .nRST(nRST), .pif(pif));
    always #5 CLK = ~CLK;
    logic [7:0] ctl;
    assign ctl = {pif.pc_en, pif.fd_en, pif.de_en, pif.em_en, pif.mw_en,
                  pif.fd_flush, pif.de_flush, pif.em_flush};
    typedef struct {
        logic ihit, dhit, memreq, memread, redirect, halt;
        logic [4:0] wsel, rs, rt;
        logic [7:0] ctl;
        int stall, flush;
    } vec_t;
    vec_t vecs[$];
    function automatic vec_t mk(logic ihit, logic dhit, logic memreq, logic memread,
                                logic redirect, logic halt, logic [4:0] wsel, logic [4:0] rs,
                                logic [4:0] rt, logic [7:0] c, int stall, int flush);
        vec_t v;
        v.ihit = ihit; v.dhit = dhit; v.memreq = memreq; v.memread = memread;
        v.redirect = redirect; v.halt = halt; v.wsel = wsel; v.rs = rs; v.rt = rt;
        v.ctl = c; v.stall = stall; v.flush = flush;
        return v;
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic drive(input vec_t v);
        pif.ihit = v.ihit; pif.dhit = v.dhit; pif.em_memreq = v.memreq;
        pif.de_memread = v.memread; pif.em_redirect = v.redirect; pif.mw_halt = v.halt;
        pif.de_wsel = v.wsel; pif.fd_rs = v.rs; pif.fd_rt = v.rt;
    endtask
    task automatic run_vec(input string name, input vec_t v);
        drive(v);
        #1;
        chk({name, " ctl"}, int'(ctl), int'(v.ctl));
        @(posedge CLK);
        #1;
        chk({name, " stall"}, int'(pif.stall_cycles), v.stall);
        chk({name, " flush"}, int'(pif.flush_count), v.flush);
    endtask
    task automatic check_reset(input string name);
        chk({name, " ctl"}, int'(ctl), 0);
        chk({name, " halted"}, int'(pif.halted), 0);
        chk({name, " stall"}, int'(pif.stall_cycles), 0);
        chk({name, " flush"}, int'(pif.flush_count), 0);
    endtask
    vec_t idle;
    initial begin
        idle = mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b11111_000, 0, 0);
        // ihit dhit memreq memread redirect halt  wsel rs rt  ctl{pc,fd,de,em,mw,fdf,def,emf}  stall flush
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 8'b11111_000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 5'd8, 5'd8, 5'd3, 8'b00011_010, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd3, 8'b11111_000, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 5'd9, 5'd0, 5'd9, 8'b00011_010, 2, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 8'b11111_000, 2, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b00000_000, 3, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b00000_000, 4, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b00000_000, 5, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b11111_000, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b00000_000, 6, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b00011_000, 7, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 8'b00001_000, 8, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b00000_000, 9, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b00000_000, 10, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b10000_111, 10, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b11111_000, 10, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 8'b10001_111, 10, 2));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 8'b00000_000, 11, 2));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b10000_111, 11, 3));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 8'b10001_111, 11, 4));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'd4, 5'd4, 5'd0, 8'b00000_000, 12, 4));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 5'd4, 5'd4, 5'd0, 8'b00011_010, 13, 4));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'd4, 5'd4, 5'd0, 8'b11111_000, 13, 4));
        drive(idle);
        #1;
        check_reset("in reset");
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int i = 0; i < vecs.size(); i++) run_vec($sformatf("vec%0d", i), vecs[i]);
        // halt from RUN: outputs die at once, halted and frozen counters afterwards
        run_vec("halt", mk(1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 8'b00000_000, 14, 4));
        chk("halt halted", int'(pif.halted), 1);
        for (int i = 0; i < 5; i++) begin
            run_vec($sformatf("halted%0d", i), mk(1, 1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 8'b0, 14, 4));
            chk($sformatf("halted%0d sticky", i), int'(pif.halted), 1);
        end
        drive(idle);
        nRST = 1'b0;
        #1;
        check_reset("reset from halt");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        run_vec("redir pend", mk(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 8'b00001_000, 1, 0));
        run_vec("redir halt", mk(1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 8'b00000_000, 2, 0));
        chk("redir halt halted", int'(pif.halted), 1);
        drive(idle);
        nRST = 1'b0;
        #1;
        check_reset("reset from redir halt");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int i = 0; i < 20; i++)
            run_vec($sformatf("sat%0d", i),
                    mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'b0, (i + 1 > 15) ? 15 : i + 1, 0));
        #2;
        drive(idle);
        nRST = 1'b0;
        #1;
        check_reset("async reset mid stall");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        run_vec("redir pend2", mk(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 8'b00001_000, 1, 0));
        #2;
        nRST = 1'b0;
        #1;
        check_reset("async reset mid redirect");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        run_vec("after redir reset", idle);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
